// File: rtl/ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_regs
// Purpose  : Carries the decoder control word from ID through the EXE, MEM and
//            WB pipeline registers. Inserts a bubble for load-use hazards and
//            branch flushes, freezes on an external stall, and keeps a
//            saturating count of stalled cycles.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            id_*                 - ID-stage instruction fields and validity
//            ext_stall            - freeze the whole pipe
//            flush                - kill the ID instruction (branch taken)
//            stall_id             - hold PC and the IF/ID register this cycle
//            ex_*/mem_*/wb_*      - per-stage valid, control fields and rd
//            stall_cnt            - saturating count of stall_id cycles
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_regs #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_exe_ctrl,
  input  logic [3:0]            id_mem_ctrl,
  input  logic [2:0]            id_wb_ctrl,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [6:0]            ex_exe_ctrl,
  output logic [3:0]            ex_mem_ctrl,
  output logic [2:0]            ex_wb_ctrl,
  output logic [3:0]            mem_mem_ctrl,
  output logic [2:0]            mem_wb_ctrl,
  output logic [2:0]            wb_wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  // EXE stage
  logic                  r_ex_valid;
  logic [6:0]            r_ex_exe;
  logic [3:0]            r_ex_mem;
  logic [2:0]            r_ex_wb;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  // MEM stage
  logic                  r_mem_valid;
  logic [3:0]            r_mem_mem;
  logic [2:0]            r_mem_wb;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  // WB stage
  logic                  r_wb_valid;
  logic [2:0]            r_wb_wb;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  // A flush that arrived while frozen; applied on the first free cycle
  logic                  r_flush_pend;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic w_ex_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_haz;
  logic w_kill;
  logic w_stall_id;

  // A load in EX (memory read that writes the register file) cannot forward
  // its data in time for a dependent instruction sitting in ID.
  assign w_ex_is_load = r_ex_valid & r_ex_mem[2] & ~r_ex_mem[0] & r_ex_wb[1];
  assign w_rs1_hit    = id_rs1_used & (id_rs1 == r_ex_rd);
  assign w_rs2_hit    = id_rs2_used & (id_rs2 == r_ex_rd);
  assign w_haz        = id_valid & w_ex_is_load & (w_rs1_hit | w_rs2_hit);
  assign w_kill       = flush | r_flush_pend;
  // A killed ID instruction is discarded anyway, so it never needs holding.
  assign w_stall_id   = ~rst & (ext_stall | (w_haz & ~w_kill));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_exe     <= '0;
      r_ex_mem     <= '0;
      r_ex_wb      <= '0;
      r_ex_rd      <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_mem    <= '0;
      r_mem_wb     <= '0;
      r_mem_rd     <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_wb      <= '0;
      r_wb_rd      <= '0;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_stall_id && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (ext_stall) begin
        // Whole pipe frozen; remember a flush so it is not lost.
        if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end else begin
        if (w_kill) begin
          r_flush_pend <= 1'b0;
        end

        r_mem_valid <= r_ex_valid;
        r_mem_mem   <= r_ex_mem;
        r_mem_wb    <= r_ex_wb;
        r_mem_rd    <= r_ex_rd;
        r_wb_valid  <= r_mem_valid;
        r_wb_wb     <= r_mem_wb;
        r_wb_rd     <= r_mem_rd;

        // Bubble is all-zero so an invalid stage can never raise a write.
        if (w_kill || w_haz || !id_valid) begin
          r_ex_valid <= 1'b0;
          r_ex_exe   <= '0;
          r_ex_mem   <= '0;
          r_ex_wb    <= '0;
          r_ex_rd    <= '0;
        end else begin
          r_ex_valid <= 1'b1;
          r_ex_exe   <= id_exe_ctrl;
          r_ex_mem   <= id_mem_ctrl;
          r_ex_wb    <= id_wb_ctrl;
          r_ex_rd    <= id_rd;
        end
      end
    end
  end

  assign stall_id     = w_stall_id;
  assign ex_valid     = r_ex_valid;
  assign mem_valid    = r_mem_valid;
  assign wb_valid     = r_wb_valid;
  assign ex_exe_ctrl  = r_ex_exe;
  assign ex_mem_ctrl  = r_ex_mem;
  assign ex_wb_ctrl   = r_ex_wb;
  assign mem_mem_ctrl = r_mem_mem;
  assign mem_wb_ctrl  = r_mem_wb;
  assign wb_wb_ctrl   = r_wb_wb;
  assign ex_rd        = r_ex_rd;
  assign mem_rd       = r_mem_rd;
  assign wb_rd        = r_wb_rd;
  assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Carries the decoder's per-instruction control word from ID through the EXE, MEM and WB pipeline registers.
- Inserts bubbles for load-use hazards and branch flushes, and freezes on an external stall.
- Sits directly downstream of the control unit; its stage outputs drive the EXE muxes, the memory port and the register-file write enables.
- Counts stall/bubble cycles for performance debug.

Parameters:
REG_ADDR_W, 3, width of register-address fields (rd/rs).
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_exe_ctrl  in  7  {sel_op, sel_ad, sel_int, opcode[3:0]} from decoder
id_mem_ctrl  in  4  {sum_mem, sel_mem, sel_data, mem_wr}
id_wb_ctrl  in  3  {sel_wb, reg_wrv, reg_wrs}
id_rd  in  REG_ADDR_W  destination register of ID instruction
id_rs1  in  REG_ADDR_W  source register 1
id_rs2  in  REG_ADDR_W  source register 2
id_rs1_used  in  1  rs1 is actually read
id_rs2_used  in  1  rs2 is actually read
ext_stall  in  1  memory/external busy; freeze whole pipe
flush  in  1  branch taken (sel_pc path); kill the ID instruction
stall_id  out  1  hold PC and the IF/ID register this cycle
ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction
ex_exe_ctrl  out  7  EXE-stage EXE controls
ex_mem_ctrl  out  4  EXE-stage MEM controls, carried forward
ex_wb_ctrl  out  3  EXE-stage WB controls, carried forward
mem_mem_ctrl  out  4  MEM-stage memory controls
mem_wb_ctrl  out  3  MEM-stage WB controls
wb_wb_ctrl  out  3  WB-stage controls; reg_wrv/reg_wrs are the final write enables
ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  destination register per stage
stall_cnt  out  CNT_W  saturating count of cycles with stall_id=1

Behaviour:
- Reset (rst=1 at edge): all stage registers, valid bits, flush_pend and stall_cnt go to 0. stall_id=0 while rst=1. Bubble encoding is all control bits 0 (opcode 0000, NOP), rd 0, valid 0.
- Hazard (combinational): haz = id_valid & ex_valid & ex_mem_ctrl.sel_mem & ~ex_mem_ctrl.mem_wr & ex_wb_ctrl.reg_wrv & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- kill = flush | flush_pend.
- stall_id = ~rst & (ext_stall | (haz & ~kill)).
- Per-edge priority when not in reset:
  1. ext_stall=1: EX, MEM and WB hold their values. If flush=1, set flush_pend=1; the flush is never dropped.
  2. Else if kill: EX <= bubble; MEM <= EX; WB <= MEM; flush_pend <= 0. Flush beats the hazard.
  3. Else if haz: EX <= bubble; MEM <= EX; WB <= MEM. The ID instruction is retained upstream via stall_id.
  4. Else: EX <= ID fields; valid = id_valid. If id_valid=0, the bubble encoding is loaded regardless of the ctrl inputs. Then MEM <= EX; WB <= MEM.
- Latency: an ID instruction appears at EX 1 cycle later, MEM 2 and WB 3, plus any stall cycles.
- Any stage with valid=0 must present all-zero controls, so no spurious mem_wr or reg_wr* is possible.
- stall_cnt increments by 1 each non-reset cycle with stall_id=1 and saturates at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall or with flush_pend set clears everything within the same cycle.
- Simultaneous haz and ext_stall: stall_id=1 and the pipe freezes. On release, the bubble is inserted only if haz is still true.

Test Plan:
- Straight-line: opcodes 0001, 0010, 0101 issued with id_valid=1 on consecutive cycles -> each appears at wb_wb_ctrl 3 cycles later with the matching bits (0001 -> 3'b110); stall_cnt stays 0.
- Load-use: load (0011: mem 4'b0110, wb 3'b010, rd=2) followed by a consumer with rs1=2, rs1_used=1 -> stall_id=1 for exactly one cycle, a bubble appears at EX, the consumer reaches EX one cycle late, stall_cnt=1. Repeat with rs1_used=0 -> no stall.
- Store is not a hazard: 0100 (mem_wr=1, reg_wrv=0) with rd=2, next instruction reading r2 -> stall_id stays 0.
- Flush vs hazard: set up the load-use case above and assert flush the same cycle -> stall_id=0, EX becomes a bubble, the load still advances to MEM.
- Flush during ext_stall: ext_stall=1 for 3 cycles with a flush pulse in cycle 2 -> all stage outputs constant for those cycles; the first free cycle shows ex_valid=0 and flush_pend cleared; stall_cnt=3.
- Reset/saturation: with CNT_W=2, hold a hazard for 5 cycles -> stall_cnt sticks at 3. Assert rst mid-sequence -> next cycle all outputs 0 and stall_id=0.
